// File: rtl/hdmi_pkg.sv
// Shared types and default constants for the HDMI clock measurement block.
// Contents: measurement FSM state enum, default gate and settle lengths.
package hdmi_pkg;

    // Measurement sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GATE     = 3'd1,
        ST_REQ      = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_CAPTURE  = 3'd5
    } meas_state_e;

    // Default gate length: one second at a 50 MHz client clock
    localparam int unsigned HDMI_GATE_CYCLES_DEF   = 32'd50_000_000;
    // Default settle time before sampling the multi-bit snapshot
    localparam int unsigned HDMI_SETTLE_CYCLES_DEF = 32'd4;

endpackage

// File: rtl/hdmi_clk_meas_stab.sv
// Stability tracker for successive HDMI clock measurements.
// Built only when HDMI_CLK_MEAS_STABLE_EN is defined.
// Ports:
//   clk, rst_n    client clock, async active-low reset
//   clear         drop history and the stable flag (measurement run aborted)
//   sample_en     a new valid measurement is being loaded this cycle
//   sample        the measurement value being loaded
//   stable        registered: 3 consecutive measurements within STABLE_TOL
`ifdef HDMI_CLK_MEAS_STABLE_EN
module hdmi_clk_meas_stab #(
    parameter int unsigned CNT_W      = 28,
    parameter int unsigned STABLE_TOL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample_en,
    input  logic [CNT_W-1:0] sample,
    output logic             stable
);

    logic [CNT_W-1:0] prev_q, prev_d;
    logic [1:0]       streak_q, streak_d;   // 0 = no history, saturates at 3
    logic             stable_d;
    logic [CNT_W-1:0] diff_c;
    logic             in_tol_c;

    // Absolute difference to the previous measurement
    always_comb begin
        diff_c   = (sample >= prev_q) ? (sample - prev_q) : (prev_q - sample);
        in_tol_c = (64'(diff_c) <= 64'(STABLE_TOL));
    end

    // Streak of in-tolerance measurements; an out-of-tolerance one restarts it
    always_comb begin
        prev_d   = prev_q;
        streak_d = streak_q;
        stable_d = stable;
        if (clear) begin
            streak_d = 2'd0;
            stable_d = 1'b0;
        end else if (sample_en) begin
            prev_d = sample;
            if (streak_q == 2'd0 || !in_tol_c) begin
                streak_d = 2'd1;
            end else if (streak_q != 2'd3) begin
                streak_d = streak_q + 2'd1;
            end
            stable_d = (streak_d == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            streak_q <= 2'd0;
            stable   <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            streak_q <= streak_d;
            stable   <= stable_d;
        end
    end

endmodule
`endif

// File: rtl/hdmi_clk_meas_ctrl.sv
// HDMI clock frequency measurement controller.
// Gates GATE_CYCLES client clocks, toggles a snapshot/reset request to the
// HDMI-domain counter, waits for the ack, lets the snapshot settle and
// captures it. The first capture after leaving IDLE covers an undefined
// interval and is discarded.
// Optional: HDMI_CLK_MEAS_STABLE_EN builds the stability tracker; without it
// meas_stable is tied low.
// Ports:
//   clk, rst_n                 client clock, async active-low reset
//   enable, pll_locked__clk    run conditions (level, already in clk domain)
//   clk_ctr_reset_req__clk     toggle request to the HDMI counter
//   clk_ctr_reset_ack__clk     ack, equals the last serviced request level
//   clk_ctr_at_reset__clk      snapshotted HDMI counter
//   meas_count, meas_valid     last measurement, one-cycle update pulse
//   ack_err, clear_err         sticky ack-timeout flag and its clear
//   meas_stable                stability flag
module hdmi_clk_meas_ctrl
    import hdmi_pkg::*;
#(
    parameter int unsigned CLK_CTR_MAX   = 27,
    parameter int unsigned GATE_CYCLES   = HDMI_GATE_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = HDMI_SETTLE_CYCLES_DEF,
    parameter int unsigned ACK_TIMEOUT   = 1024,
    parameter int unsigned STABLE_TOL    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   pll_locked__clk,
    output logic                   clk_ctr_reset_req__clk,
    input  logic                   clk_ctr_reset_ack__clk,
    input  logic [CLK_CTR_MAX:0]   clk_ctr_at_reset__clk,
    output logic [CLK_CTR_MAX:0]   meas_count,
    output logic                   meas_valid,
    output logic                   ack_err,
    input  logic                   clear_err,
    output logic                   meas_stable
);

    localparam int unsigned CNT_W    = CLK_CTR_MAX + 1;
    localparam int unsigned GATE_W   = $clog2(GATE_CYCLES + 1);
    localparam int unsigned ACK_W    = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    // Elaboration-time parameter sanity
    if (GATE_CYCLES < 1 || SETTLE_CYCLES < 1 || ACK_TIMEOUT < 1) begin : g_bad_len
        $error("hdmi_clk_meas_ctrl: GATE_CYCLES, SETTLE_CYCLES and ACK_TIMEOUT must be >= 1");
    end
    if (64'(STABLE_TOL) >= (64'd1 << CNT_W)) begin : g_bad_tol
        $error("hdmi_clk_meas_ctrl: STABLE_TOL exceeds the count range");
    end

    meas_state_e         state_q, state_d;
    logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                req_d;
    logic                discard_q, discard_d;
    logic [CNT_W-1:0]    meas_count_d;
    logic                meas_valid_d;
    logic                ack_err_d;
    logic                run_c;

    assign run_c = enable & pll_locked__clk;

    // Next-state and register-update logic
    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        ack_cnt_d    = ack_cnt_q;
        settle_cnt_d = settle_cnt_q;
        req_d        = clk_ctr_reset_req__clk;
        discard_d    = discard_q;
        meas_count_d = meas_count;
        meas_valid_d = 1'b0;
        // A timeout below overrides the clear
        ack_err_d    = clear_err ? 1'b0 : ack_err;

        if (state_q != ST_IDLE && !run_c) begin
            // Abort: hold req level and measurement, no pulse
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (run_c) begin
                        state_d    = ST_GATE;
                        gate_cnt_d = '0;
                        discard_d  = 1'b1;
                    end
                end
                ST_GATE: begin
                    if (gate_cnt_q == GATE_W'(GATE_CYCLES - 1)) begin
                        state_d = ST_REQ;
                    end else begin
                        gate_cnt_d = gate_cnt_q + GATE_W'(1);
                    end
                end
                ST_REQ: begin
                    req_d     = ~clk_ctr_reset_req__clk;
                    ack_cnt_d = '0;
                    state_d   = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (clk_ctr_reset_ack__clk == clk_ctr_reset_req__clk) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = '0;
                    end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                        ack_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        ack_cnt_d = ack_cnt_q + ACK_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    state_d    = ST_GATE;
                    gate_cnt_d = '0;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        meas_count_d = clk_ctr_at_reset__clk;
                        meas_valid_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q                <= ST_IDLE;
            gate_cnt_q             <= '0;
            ack_cnt_q              <= '0;
            settle_cnt_q           <= '0;
            clk_ctr_reset_req__clk <= 1'b0;
            discard_q              <= 1'b1;
            meas_count             <= '0;
            meas_valid             <= 1'b0;
            ack_err                <= 1'b0;
        end else begin
            state_q                <= state_d;
            gate_cnt_q             <= gate_cnt_d;
            ack_cnt_q              <= ack_cnt_d;
            settle_cnt_q           <= settle_cnt_d;
            clk_ctr_reset_req__clk <= req_d;
            discard_q              <= discard_d;
            meas_count             <= meas_count_d;
            meas_valid             <= meas_valid_d;
            ack_err                <= ack_err_d;
        end
    end

`ifdef HDMI_CLK_MEAS_STABLE_EN
    logic abort_c;
    logic cap_fire_c;

    assign abort_c    = (state_q != ST_IDLE) && !run_c;
    assign cap_fire_c = (state_q == ST_CAPTURE) && run_c && !discard_q;

    hdmi_clk_meas_stab #(
        .CNT_W      (CNT_W),
        .STABLE_TOL (STABLE_TOL)
    ) u_stab (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (abort_c),
        .sample_en (cap_fire_c),
        .sample    (clk_ctr_at_reset__clk),
        .stable    (meas_stable)
    );
`else
    assign meas_stable = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_clk_meas_ctrl.sv
// Self-checking bench for hdmi_clk_meas_ctrl with a short gate.
// An ack responder echoes each req toggle after ACK_DLY clocks and presents
// the next queued snapshot; expected counts, period and stability come from
// a behavioural model of the measurement rules.
`timescale 1ns/1ps
module tb_hdmi_clk_meas_ctrl;
    import hdmi_pkg::*;

    localparam int unsigned CLK_CTR_MAX = 27;
    localparam int unsigned GATE_C      = 100;
    localparam int unsigned SETTLE_C    = 4;
    localparam int unsigned TIMEOUT_C   = 16;
    localparam int unsigned TOL         = 2;
    localparam int          ACK_DLY     = 3;
    // Cycles spent in WAIT_ACK: mismatch until the echo lands, then the match cycle
    localparam int          ACK_LAT     = ACK_DLY + 1;
    localparam int          PERIOD      = GATE_C + 1 + ACK_LAT + SETTLE_C + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic                 pll_locked;
    logic                 req;
    logic                 ack;
    logic [CLK_CTR_MAX:0] snapshot;
    logic [CLK_CTR_MAX:0] meas_count;
    logic                 meas_valid;
    logic                 ack_err;
    logic                 clear_err;
    logic                 meas_stable;

    int checks = 0;
    int errors = 0;

    logic                 ack_en;
    logic                 last_req;
    logic [CLK_CTR_MAX:0] snap_q[$];
    logic [CLK_CTR_MAX:0] exp_q[$];
    logic [CLK_CTR_MAX:0] m_prev;
    int                   m_streak;

    hdmi_clk_meas_ctrl #(
        .CLK_CTR_MAX   (CLK_CTR_MAX),
        .GATE_CYCLES   (GATE_C),
        .SETTLE_CYCLES (SETTLE_C),
        .ACK_TIMEOUT   (TIMEOUT_C),
        .STABLE_TOL    (TOL)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .enable                 (enable),
        .pll_locked__clk        (pll_locked),
        .clk_ctr_reset_req__clk (req),
        .clk_ctr_reset_ack__clk (ack),
        .clk_ctr_at_reset__clk  (snapshot),
        .meas_count             (meas_count),
        .meas_valid             (meas_valid),
        .ack_err                (ack_err),
        .clear_err              (clear_err),
        .meas_stable            (meas_stable)
    );

    always #5 clk = ~clk;

    // HDMI-side responder: on a req toggle, after ACK_DLY clocks present a new snapshot and echo the ack
    initial begin
        ack      = 1'b0;
        last_req = 1'b0;
        snapshot = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ack      = 1'b0;
                last_req = 1'b0;
            end else if (req !== last_req) begin
                last_req = req;
                if (ack_en) begin
                    repeat (ACK_DLY) @(posedge clk);
                    #1;
                    if (rst_n) begin
                        if (snap_q.size() != 0) snapshot = snap_q.pop_front();
                        else                    snapshot = 28'd400;
                        ack = last_req;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stability rule: streak of measurements each within TOL of the previous, stable at 3
    task automatic model_stable(input logic [CLK_CTR_MAX:0] v, output logic exp_st);
        longint d;
        d = (v > m_prev) ? longint'(v - m_prev) : longint'(m_prev - v);
        if (m_streak == 0 || d > longint'(TOL)) m_streak = 1;
        else                                    m_streak = m_streak + 1;
        m_prev = v;
`ifdef HDMI_CLK_MEAS_STABLE_EN
        exp_st = (m_streak >= 3);
`else
        exp_st = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        pll_locked = 1'b0;
        clear_err  = 1'b0;
        ack_en     = 1'b1;
        snap_q.delete();
        exp_q.delete();
        m_streak   = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output logic got, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!meas_valid && n < budget);
        got = meas_valid;
    endtask

    task automatic wait_req_change(input int budget, output logic got);
        logic lvl;
        int   n;
        lvl = req;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req === lvl && n < budget);
        got = (req !== lvl);
    endtask

    initial begin
        logic                 got;
        logic                 exp_st;
        logic                 saw_valid;
        logic                 req_save;
        logic [CLK_CTR_MAX:0] cnt_save;
        logic [CLK_CTR_MAX:0] base;
        int                   n;

        // Reset values
        do_reset();
        chk("rst_req",    64'(req),         64'd0);
        chk("rst_count",  64'(meas_count),  64'd0);
        chk("rst_valid",  64'(meas_valid),  64'd0);
        chk("rst_err",    64'(ack_err),     64'd0);
        chk("rst_stable", 64'(meas_stable), 64'd0);
        chk("rst_state",  64'(dut.state_q), 64'(ST_IDLE));

        // Directed and randomized measurement run; first snapshot is discarded
        snap_q.push_back(28'd111);
        exp_q.push_back(28'd400);
        exp_q.push_back(28'd401);
        exp_q.push_back(28'd399);
        exp_q.push_back(28'd410);
        exp_q.push_back(28'h0FF_FFFF);
        base = 28'($urandom_range(1000, 1000000));
        for (int i = 0; i < 4; i++) exp_q.push_back(base + 28'($urandom_range(0, 3)));
        foreach (exp_q[i]) snap_q.push_back(exp_q[i]);
        enable     = 1'b1;
        pll_locked = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            wait_valid(3 * PERIOD, got, n);
            chk("valid_seen", 64'(got), 64'd1);
            if (i > 0) chk("period", 64'(n), 64'(PERIOD));
            chk("meas_count", 64'(meas_count), 64'(exp_q[i]));
            model_stable(exp_q[i], exp_st);
            chk("meas_stable", 64'(meas_stable), 64'(exp_st));
        end
        @(negedge clk);
        chk("valid_one_cycle", 64'(meas_valid), 64'd0);

        // Lock drop during GATE: abort to IDLE with outputs held
        repeat (20) @(negedge clk);
        req_save   = req;
        cnt_save   = meas_count;
        pll_locked = 1'b0;
        @(negedge clk);
        chk("abort_state",  64'(dut.state_q), 64'(ST_IDLE));
        chk("abort_stable", 64'(meas_stable), 64'd0);
        saw_valid = meas_valid;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clk);
            saw_valid = saw_valid | meas_valid;
        end
        chk("abort_no_valid", 64'(saw_valid),  64'd0);
        chk("abort_req_held", 64'(req),        64'(req_save));
        chk("abort_count",    64'(meas_count), 64'(cnt_save));

        // Relock: the first capture after IDLE is discarded again
        snap_q.delete();
        snap_q.push_back(28'd222);
        snap_q.push_back(28'd555);
        m_streak   = 0;
        pll_locked = 1'b1;
        wait_valid(3 * PERIOD, got, n);
        chk("relock_valid", 64'(got),        64'd1);
        chk("relock_count", 64'(meas_count), 64'd555);

        // Asynchronous reset while the snapshot settles
        n = 0;
        while (dut.state_q !== ST_SETTLE && n < 2 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        chk("reach_settle", 64'(dut.state_q), 64'(ST_SETTLE));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_count",  64'(meas_count),  64'd0);
        chk("async_req",    64'(req),         64'd0);
        chk("async_valid",  64'(meas_valid),  64'd0);
        chk("async_err",    64'(ack_err),     64'd0);
        chk("async_stable", 64'(meas_stable), 64'd0);
        chk("async_state",  64'(dut.state_q), 64'(ST_IDLE));

        // Ack timeout with the responder silent
        do_reset();
        ack_en     = 1'b0;
        enable     = 1'b1;
        pll_locked = 1'b1;
        wait_req_change(2 * PERIOD, got);
        chk("to_req_toggle", 64'(got), 64'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_err && n < 2 * int'(TIMEOUT_C));
        chk("to_latency", 64'(n),            64'(TIMEOUT_C));
        chk("to_err",     64'(ack_err),      64'd1);
        chk("to_state",   64'(dut.state_q),  64'(ST_IDLE));
        clear_err = 1'b1;
        @(negedge clk);
        chk("clear_err", 64'(ack_err), 64'd0);

        // Stale ack matches the next toggle; the one after times out while clear is held
        wait_req_change(2 * PERIOD, got);
        chk("stale_match_toggle", 64'(got), 64'd1);
        wait_req_change(2 * PERIOD, got);
        chk("second_toggle", 64'(got), 64'd1);
        repeat (TIMEOUT_C - 1) @(negedge clk);
        chk("pre_timeout_err", 64'(ack_err), 64'd0);
        @(negedge clk);
        chk("set_wins", 64'(ack_err), 64'd1);
        @(negedge clk);
        chk("clear_after_set", 64'(ack_err), 64'd0);
        clear_err = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
